// File: rtl/ttl163_timer_pkg.sv
// Shared types and constants for the TTL163-based timer controller.
package ttl163_timer_pkg;

  // Width of one cascaded counter cell.
  localparam int STAGE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/TTL74x163a.sv
// Behavioural model of one 74x163 cell: synchronous clear, synchronous load,
// count enabled by CEP&CET, ripple carry TC = CET & (Q == 15).
module TTL74x163a
  import ttl163_timer_pkg::*;
(
  input  logic               clk,
  input  logic               sr_n,
  input  logic               pe_n,
  input  logic               cep,
  input  logic               cet,
  input  logic [STAGE_W-1:0] p,
  output logic [STAGE_W-1:0] q,
  output logic               tc
);

  // Counter register: clear beats load, load beats count, otherwise hold.
  always_ff @(posedge clk) begin
    if (!sr_n) begin
      q <= {STAGE_W{1'b0}};
    end else if (!pe_n) begin
      q <= p;
    end else if (cep && cet) begin
      q <= q + {{(STAGE_W-1){1'b0}}, 1'b1};
    end else begin
      q <= q;
    end
  end

  assign tc = cet & (q == {STAGE_W{1'b1}});

endmodule

// File: rtl/ttl163_timer_ctrl.sv
// Programmable periodic / one-shot timer built from a chain of 74x163 cells.
// The chain is preset to 2^W - period and counts up; its terminal count marks
// an expiry, which either reloads the preset (periodic) or freezes the chain
// at all-ones and returns to IDLE (one-shot).
module ttl163_timer_ctrl
  import ttl163_timer_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       oneshot,
  input  logic                       cfg_we,
  input  logic [STAGE_W*STAGES-1:0]  cfg_period,
  output logic                       busy,
  output logic                       tick,
  output logic                       done,
  output logic [STAGE_W*STAGES-1:0]  count
);

  localparam int W = STAGE_W * STAGES;

  timer_state_e        state_r;
  timer_state_e        state_nxt_s;
  logic [W-1:0]        shadow_r;
  logic [W-1:0]        period_r;
  logic                oneshot_r;
  logic                tick_r;
  logic                done_r;
  logic                busy_r;
  logic                capture_s;
  logic                done_set_s;

  logic                cep_s;
  logic                cet_s;
  logic                pe_n_s;
  logic                sr_n_s;
  logic [W-1:0]        preset_s;
  logic [STAGES-1:0]   stage_tc_s;
  logic                chain_tc_s;

  // Two's-complement of the period: counting up from here hits all-ones after period-1 steps.
  assign preset_s   = {W{1'b0}} - period_r;
  assign chain_tc_s = &stage_tc_s;

  // Counter chain: carry ripples through CET, all other controls are shared.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic cet_g_s;
    if (g == 0) begin : g_first
      assign cet_g_s = cet_s;
    end else begin : g_next
      assign cet_g_s = stage_tc_s[g-1];
    end
    TTL74x163a u_cell (
      .clk  (clk),
      .sr_n (sr_n_s),
      .pe_n (pe_n_s),
      .cep  (cep_s),
      .cet  (cet_g_s),
      .p    (preset_s[STAGE_W*g +: STAGE_W]),
      .q    (count[STAGE_W*g +: STAGE_W]),
      .tc   (stage_tc_s[g])
    );
  end

  // Chain controls, decoded directly from state, reset, stop and terminal count.
  always_comb begin
    cep_s  = 1'b0;
    cet_s  = 1'b0;
    pe_n_s = 1'b1;
    sr_n_s = 1'b1;
    if (rst) begin
      sr_n_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cet_s = 1'b0;
        end
        LOAD: begin
          cet_s = 1'b1;
          if (stop) begin
            pe_n_s = 1'b1;
          end else begin
            pe_n_s = 1'b0;
          end
        end
        RUN: begin
          cet_s = 1'b1;
          if (stop) begin
            cep_s = 1'b0;
          end else if (chain_tc_s && oneshot_r) begin
            cep_s = 1'b0;
          end else if (chain_tc_s) begin
            cep_s  = 1'b1;
            pe_n_s = 1'b0;
          end else begin
            cep_s = 1'b1;
          end
        end
        default: begin
          cet_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic; stop wins over start, restart wins over one-shot expiry.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    done_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_nxt_s = LOAD;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          state_nxt_s = LOAD;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          state_nxt_s = LOAD;
          capture_s   = 1'b1;
        end else if (chain_tc_s && oneshot_r) begin
          state_nxt_s = IDLE;
          done_set_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= (state_r == RUN) && chain_tc_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (capture_s) begin
        done_r <= 1'b0;
      end else if (done_set_s) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Shadow period, plus the period and mode frozen for the current run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r  <= {W{1'b1}};
      period_r  <= {W{1'b1}};
      oneshot_r <= 1'b0;
    end else begin
      if (capture_s) begin
        period_r  <= shadow_r;
        oneshot_r <= oneshot;
      end else begin
        period_r  <= period_r;
        oneshot_r <= oneshot_r;
      end
      if (cfg_we && (cfg_period != {W{1'b0}})) begin
        shadow_r <= cfg_period;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign tick = tick_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_ttl163_timer_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a cycle-level behavioural model of the timer.
module tb_ttl163_timer_ctrl;
  import ttl163_timer_pkg::*;

  localparam int STAGES = 2;
  localparam int W      = 8;
  localparam int MAXV   = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         oneshot;
  logic         cfg_we;
  logic [W-1:0] cfg_period;
  logic         busy;
  logic         tick;
  logic         done;
  logic [W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: phase 0 = idle, 1 = loading, 2 = running.
  int m_phase, m_count, m_shadow, m_period, m_tick, m_done, m_oneshot;
  int cyc_n = 0;
  int tick_q[$];
  int c;

  always #5 clk = ~clk;

  ttl163_timer_ctrl #(.STAGES(STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .busy       (busy),
    .tick       (tick),
    .done       (done),
    .count      (count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    int tc;
    int preset;
    int nphase;
    if (rst) begin
      m_phase = 0; m_count = 0; m_tick = 0; m_done = 0;
      m_shadow = MAXV; m_period = MAXV; m_oneshot = 0;
    end else begin
      tc     = (m_phase == 2 && m_count == MAXV) ? 1 : 0;
      preset = (MAXV + 1 - m_period) % (MAXV + 1);
      m_tick = tc;
      if (m_phase == 1 && !stop) begin
        m_count = preset;
      end else if (m_phase == 2 && !stop) begin
        if (!tc) m_count = m_count + 1;
        else if (m_oneshot == 0) m_count = preset;
      end
      nphase = m_phase;
      if (m_phase != 0 && stop) begin
        nphase = 0;
      end else if (start && !stop) begin
        nphase = 1; m_period = m_shadow; m_oneshot = oneshot; m_done = 0;
      end else if (m_phase == 1) begin
        nphase = 2;
      end else if (m_phase == 2 && tc == 1 && m_oneshot == 1) begin
        nphase = 0; m_done = 1;
      end
      m_phase = nphase;
      if (cfg_we && cfg_period != 0) m_shadow = cfg_period;
    end
  endtask

  // One cycle: compare outputs, drive new inputs, clock the edge, update the model.
  task automatic cyc(input bit s, input bit p, input bit os, input bit we, input int per, input bit r);
    @(negedge clk);
    check_val("count", count, m_count);
    check_val("tick",  tick,  m_tick);
    check_val("done",  done,  m_done);
    check_val("busy",  busy,  (m_phase != 0) ? 1 : 0);
    if (tick) tick_q.push_back(cyc_n);
    start = s; stop = p; oneshot = os; cfg_we = we; cfg_period = per[W-1:0]; rst = r;
    @(posedge clk);
    model_edge();
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_spacing(input string tag, input int gap);
    check_val({tag, "_n"}, (tick_q.size() >= 2) ? 1 : 0, 1);
    for (int i = 1; i < tick_q.size(); i++) check_val(tag, tick_q[i] - tick_q[i-1], gap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; cfg_we = 1'b0; cfg_period = '0;
    repeat (2) begin @(posedge clk); model_edge(); end

    // Reset state
    #1;
    check_val("rst_count",  count, 8'h00);
    check_val("rst_tick",   tick,  1'b0);
    check_val("rst_done",   done,  1'b0);
    check_val("rst_busy",   busy,  1'b0);
    check_val("rst_shadow", dut.shadow_r, 8'hFF);
    idle(2);

    // Periodic, period 5
    cyc(0, 0, 0, 1, 5, 0); idle(2);
    c = cyc_n; tick_q.delete();
    cyc(1, 0, 0, 0, 0, 0);
    idle(1); #1; check_val("per_busy", busy, 1'b1);
    idle(20);
    check_val("per_n", (tick_q.size() >= 3) ? 1 : 0, 1);
    if (tick_q.size() >= 3) begin
      check_val("per_t0", tick_q[0], c + 7);
      check_val("per_t1", tick_q[1], c + 12);
      check_val("per_t2", tick_q[2], c + 17);
    end
    cyc(0, 1, 0, 0, 0, 0); idle(3);

    // One-shot, period 3
    cyc(0, 0, 0, 1, 3, 0); idle(1);
    c = cyc_n; tick_q.delete();
    cyc(1, 0, 1, 0, 0, 0); idle(8);
    #1;
    check_val("os_n",     tick_q.size(), 1);
    if (tick_q.size() == 1) check_val("os_t0", tick_q[0], c + 5);
    check_val("os_done",  done,  1'b1);
    check_val("os_count", count, 8'hFF);
    check_val("os_busy",  busy,  1'b0);

    // Stop mid-run at 0xFC
    cyc(0, 0, 0, 1, 10, 0); idle(1);
    tick_q.delete();
    cyc(1, 0, 0, 0, 0, 0); idle(7);
    #1; check_val("stop_pre", count, 8'hFC);
    cyc(0, 1, 0, 0, 0, 0); idle(4);
    #1;
    check_val("stop_count", count, 8'hFC);
    check_val("stop_done",  done,  1'b0);
    check_val("stop_busy",  busy,  1'b0);
    check_val("stop_ntick", tick_q.size(), 0);

    // Reconfigure during a period-4 run
    cyc(0, 0, 0, 1, 4, 0); idle(1);
    tick_q.delete();
    cyc(1, 0, 0, 0, 0, 0); idle(6);
    cyc(0, 0, 0, 1, 7, 0); idle(14);
    check_spacing("cfg_gap4", 4);
    cyc(1, 0, 0, 0, 0, 0); idle(2);
    tick_q.delete(); idle(25);
    check_spacing("cfg_gap7", 7);
    cyc(0, 0, 0, 1, 0, 0);
    #1; check_val("cfg_zero", dut.shadow_r, 8'h07);
    cyc(0, 1, 0, 0, 0, 0); idle(2);

    // Period 1: tick every cycle
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0); idle(3);
    tick_q.delete(); idle(10);
    check_val("p1_n", tick_q.size(), 10);
    cyc(0, 1, 0, 0, 0, 0); idle(3);

    // Stop coincident with terminal count
    cyc(0, 0, 0, 1, 3, 0);
    c = cyc_n;
    cyc(1, 0, 0, 0, 0, 0); idle(3);
    tick_q.delete();
    cyc(0, 1, 0, 0, 0, 0); idle(4);
    #1;
    check_val("sc_n", tick_q.size(), 1);
    if (tick_q.size() == 1) check_val("sc_t0", tick_q[0], c + 5);
    check_val("sc_done",  done,  1'b0);
    check_val("sc_busy",  busy,  1'b0);
    check_val("sc_count", count, 8'hFF);

    // Reset mid-run for two edges
    cyc(0, 0, 0, 1, 5, 0);
    cyc(1, 0, 0, 0, 0, 0); idle(4);
    cyc(0, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 1);
    #1;
    check_val("mr_count",  count, 8'h00);
    check_val("mr_tick",   tick,  1'b0);
    check_val("mr_done",   done,  1'b0);
    check_val("mr_busy",   busy,  1'b0);
    check_val("mr_state",  dut.state_r, IDLE);
    check_val("mr_shadow", dut.shadow_r, 8'hFF);
    tick_q.delete(); idle(8);
    check_val("mr_ntick", tick_q.size(), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < 2),
          $urandom_range(0, 1),
          ($urandom_range(0, 99) < 5),
          $urandom_range(0, 12),
          ($urandom_range(0, 999) < 3));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
